// File: rtl/dmem_pkg.sv
// Shared types and helpers for the latency-programmable data memory.
package dmem_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        DONE = 2'd2
    } dmem_state_t;

    // Byte geometry of the default 32-bit word.
    localparam int WORD_BYTES = 4;
    localparam int OFFS_W     = 2;

    function automatic int word_bytes(input int data_w);
        return data_w / 8;
    endfunction

    function automatic int offs_w(input int data_w);
        return $clog2(data_w / 8);
    endfunction

endpackage

// File: rtl/dmem_stall_ctrl_if.sv
// Request/response/stall bundle between the MEM stage and the data memory.
interface dmem_stall_ctrl_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 32,
    parameter int CNT_W  = 16
);
    logic                  req_valid;
    logic                  req_we;
    logic [ADDR_W-1:0]     req_addr;
    logic [DATA_W-1:0]     req_wdata;
    logic [DATA_W/8-1:0]   req_be;
    logic                  stall;
    logic                  rsp_valid;
    logic [DATA_W-1:0]     rsp_rdata;
    logic                  rsp_err;
    logic [CNT_W-1:0]      stall_count;

    modport master (
        output req_valid, req_we, req_addr, req_wdata, req_be,
        input  stall, rsp_valid, rsp_rdata, rsp_err, stall_count
    );

    modport slave (
        input  req_valid, req_we, req_addr, req_wdata, req_be,
        output stall, rsp_valid, rsp_rdata, rsp_err, stall_count
    );
endinterface

// File: rtl/dmem_bytelane_ram.sv
// Word-organised RAM: synchronous byte-lane writes, asynchronous read.
module dmem_bytelane_ram #(
    parameter int  DATA_W      = 32,
    parameter int  DEPTH_WORDS = 64,
    localparam int IDX_W       = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1,
    localparam int NB          = DATA_W / 8
) (
    input  logic              clk,
    input  logic              we_i,
    input  logic [IDX_W-1:0]  idx_i,
    input  logic [NB-1:0]     be_i,
    input  logic [DATA_W-1:0] wdata_i,
    output logic [DATA_W-1:0] rdata_o
);
    logic [DATA_W-1:0] mem_q [DEPTH_WORDS];

    always_ff @(posedge clk) begin
        if (we_i) begin
            for (int b = 0; b < NB; b++) begin
                if (be_i[b]) begin
                    mem_q[idx_i][b*8 +: 8] <= wdata_i[b*8 +: 8];
                end
            end
        end
    end

    assign rdata_o = mem_q[idx_i];
endmodule

// File: rtl/dmem_stall_ctrl.sv
// MEM-stage data memory with programmable access latency, fault reporting
// and a stall line into the hazard unit. One outstanding request at a time.
module dmem_stall_ctrl
    import dmem_pkg::*;
#(
    parameter int DATA_W      = 32,
    parameter int ADDR_W      = 32,
    parameter int DEPTH_WORDS = 64,
    parameter int LATENCY     = 2,
    parameter int CNT_W       = 16
) (
    input  logic              clk,
    input  logic              reset,
    dmem_stall_ctrl_if.slave  bus
);
    localparam int NB    = word_bytes(DATA_W);
    localparam int OW    = offs_w(DATA_W);
    localparam int IX_W  = ADDR_W - OW;
    localparam int IDX_W = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
    localparam int CW    = (LATENCY > 2) ? $clog2(LATENCY) : 1;

    if (LATENCY < 1) begin : g_bad_latency
        $error("dmem_stall_ctrl: LATENCY must be >= 1");
    end
    if ((DATA_W % 8) != 0) begin : g_bad_width
        $error("dmem_stall_ctrl: DATA_W must be a multiple of 8");
    end

    dmem_state_t       state_q, state_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [CNT_W-1:0]  stall_count_q, stall_count_d;
    logic              we_q, we_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [NB-1:0]     be_q, be_d;
    logic              err_q, err_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;

    logic              stall;
    logic              ram_we;
    logic [DATA_W-1:0] ram_rdata;
    logic [IX_W-1:0]   req_ix;
    logic              req_fault;

    // Misalignment only faults loads and full-word stores; partial stores
    // may legally carry a nonzero byte offset.
    assign req_ix    = bus.req_addr[ADDR_W-1:OW];
    assign req_fault = (req_ix >= IX_W'(DEPTH_WORDS)) ||
                       ((|bus.req_addr[OW-1:0]) && (!bus.req_we || (&bus.req_be)));

    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        we_d          = we_q;
        idx_d         = idx_q;
        wdata_d       = wdata_q;
        be_d          = be_q;
        err_d         = err_q;
        rdata_d       = rdata_q;
        stall         = 1'b0;
        ram_we        = 1'b0;

        case (state_q)
            IDLE: begin
                stall = bus.req_valid;
                if (bus.req_valid) begin
                    we_d    = bus.req_we;
                    idx_d   = req_ix[IDX_W-1:0];
                    wdata_d = bus.req_wdata;
                    be_d    = bus.req_be;
                    err_d   = req_fault;
                    cnt_d   = CW'(LATENCY - 1);
                    state_d = WAIT;
                end
            end
            WAIT: begin
                stall = 1'b1;
                if (cnt_q == '0) begin
                    ram_we  = we_q && !err_q;
                    rdata_d = (we_q || err_q) ? '0 : ram_rdata;
                    state_d = DONE;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        stall_count_d = stall_count_q;
        if (stall && (stall_count_q != '1)) begin
            stall_count_d = stall_count_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q       <= IDLE;
            cnt_q         <= '0;
            stall_count_q <= '0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            stall_count_q <= stall_count_d;
        end
    end

    always_ff @(posedge clk) begin
        we_q    <= we_d;
        idx_q   <= idx_d;
        wdata_q <= wdata_d;
        be_q    <= be_d;
        err_q   <= err_d;
        rdata_q <= rdata_d;
    end

    // A reset landing on the access cycle must not let the write through.
    dmem_bytelane_ram #(
        .DATA_W      (DATA_W),
        .DEPTH_WORDS (DEPTH_WORDS)
    ) u_ram (
        .clk     (clk),
        .we_i    (ram_we && reset),
        .idx_i   (idx_q),
        .be_i    (be_q),
        .wdata_i (wdata_q),
        .rdata_o (ram_rdata)
    );

    assign bus.stall       = stall;
    assign bus.rsp_valid   = (state_q == DONE);
    assign bus.rsp_rdata   = (state_q == DONE) ? rdata_q : '0;
    assign bus.rsp_err     = (state_q == DONE) && err_q;
    assign bus.stall_count = stall_count_q;
endmodule
